fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage of the 16-bit microprocessor. Holds the 8-bit program counter and drives it to the PC incrementer (`adder`), taking the incremented value back as the sequential next PC. Runs a request/acknowledge fetch from instruction memory and hands each 16-bit instruction to decode over a valid/ready handshake. Supports jump redirect and halt.

## Interface
Parameters:
- `ADDR_W`, 8: PC and memory address width; must match the incrementer width.
- `INSTR_W`, 16: instruction width.
- `RESET_PC`, 8'h00: PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc_out`  out  ADDR_W  current PC; drives incrementer `in`.
- `pc_inc`  in  ADDR_W  incrementer `out` (expected `pc_out + 1`, mod 2^ADDR_W).
- `mem_req`  out  1  fetch request to instruction memory.
- `mem_addr`  out  ADDR_W  fetch address; equals `pc_out`.
- `mem_ack`  in  1  memory has `mem_rdata` valid this cycle.
- `mem_rdata`  in  INSTR_W  instruction word.
- `instr`  out  INSTR_W  fetched instruction to decode.
- `instr_pc`  out  ADDR_W  address `instr` was fetched from.
- `instr_valid`  out  1  `instr`/`instr_pc` valid.
- `instr_ready`  in  1  decode accepts the instruction.
- `jump_en`  in  1  redirect request, one-cycle pulse.
- `jump_target`  in  ADDR_W  redirect address.
- `halt`  in  1  stop fetching after the current instruction is handed off.
- `halted`  out  1  unit is in HALT.

## Operation
- States: IDLE, FETCH, HOLD, HALT.
- IDLE: entered only by reset; moves to FETCH on the first clock edge after `rst` is released.
- FETCH: `mem_req`=1, `mem_addr`=PC.
  - On `mem_ack` (no jump): `instr`<=`mem_rdata`, `instr_pc`<=PC, PC<=`pc_inc`, then go to HOLD.
- HOLD: `instr_valid`=1, `mem_req`=0.
  - On `instr_ready`: go to HALT if `halt`=1, otherwise to FETCH.
  - Without `instr_ready`: stay in HOLD; `instr` and `instr_pc` stay stable.
- HALT: `halted`=1, `mem_req`=0, `instr_valid`=0. Leave only on `jump_en`: PC<=`jump_target`, go to FETCH.
- Jump has priority over everything except reset:
  - FETCH with `jump_en`: PC<=`jump_target`, stay in FETCH. A simultaneous `mem_ack` is discarded and `instr` is not updated.
  - HOLD with `jump_en`: the held instruction is squashed (`instr_valid` drops next cycle, even if `instr_ready`=1 that cycle), PC<=`jump_target`, go to FETCH. `halt` is ignored that cycle.
  - IDLE with `jump_en`: PC<=`jump_target`, go to FETCH.
- `halt` has no effect in FETCH; an in-flight request is never abandoned except by jump or reset.
- Wrap-around: PC is taken unmodified from `pc_inc`, so 8'hFF advances to 8'h00. There is no overflow flag.
- Handshake rules:
  - `mem_addr` is stable while `mem_req`=1 until `mem_ack` or jump.
  - `mem_ack` is ignored when `mem_req`=0.
  - `mem_ack` may arrive in the same cycle `mem_req` rises.

## Timing
- Reset values, applied asynchronously and held while `rst`=1:
  - state=IDLE; PC=`RESET_PC` (so `pc_out`=`mem_addr`=`RESET_PC`).
  - `mem_req`=0; `instr`=0; `instr_pc`=0; `instr_valid`=0; `halted`=0.
- Reset during FETCH or HOLD: `mem_req` and `instr_valid` drop immediately (combinational from state); the pending memory response is discarded.
- Output decoding: `mem_req`, `instr_valid` and `halted` decode from state only; `instr`, `instr_pc` and PC are registers.
- Latency:
  - `mem_ack` in cycle N gives `instr_valid`=1 and the new PC in cycle N+1.
  - `instr_ready` in cycle M gives `mem_req`=1 in cycle M+1.
- Throughput: at best one instruction per 2 cycles (FETCH with immediate ack, then HOLD with ready).
- Jump to effect: `jump_en` in cycle N gives `mem_addr`=`jump_target` with `mem_req`=1 in cycle N+1.

## Test plan
- Reset then streaming, with memory acking every request in the same cycle and `instr_ready`=1:
  - `mem_addr` sequence is 00, 01, 02…
  - `instr_pc` matches each `mem_addr`, and `instr` equals the memory word for that address.
  - First `mem_req` appears 1 cycle after reset release.
- Memory wait states (ack delayed 3 cycles): `mem_req`/`mem_addr` held stable for 4 cycles, then `instr_valid` asserts the next cycle. Decode backpressure (ready low 5 cycles): `instr`/`instr_valid` stable, no new `mem_req`.
- Wrap: force PC to 8'hFF via jump, fetch, then check the next `mem_addr`=8'h00 and `instr_pc`=8'hFF.
- Jump cases:
  - Jump to 8'h40 with a simultaneous `mem_ack`: data is dropped, `instr` is unchanged, next `mem_addr`=8'h40.
  - Jump in HOLD with `instr_ready`=1: `instr_valid` drops and is never counted as accepted.
- Halt and restart:
  - `halt`=1 during FETCH: that instruction is still delivered, then `halted`=1 and `mem_req` stays low for 10 cycles.
  - `jump_en` to 8'h10 then resumes fetch at 8'h10 with `halted`=0.
- Async reset asserted mid-HOLD between clock edges:
  - `instr_valid` and `mem_req` go to 0 immediately, `pc_out`=`RESET_PC`.
  - Normal fetch resumes from `RESET_PC` after release.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, runs a req/ack fetch from instruction memory
// and hands each instruction to decode over valid/ready, with jump redirect and halt.
module fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  pc_out,
    input  logic [ADDR_W-1:0]  pc_inc,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               jump_en,
    input  logic [ADDR_W-1:0]  jump_target,
    input  logic               halt,
    output logic               halted
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [ADDR_W-1:0]   pc_r;
    logic [ADDR_W-1:0]   pc_nx_s;
    logic [ADDR_W-1:0]   instr_pc_r;
    logic [INSTR_W-1:0]  instr_r;
    logic                capture_s;

    // Next state, next PC and instruction capture; jump overrides ack, ready and halt
    always_comb begin
        state_nx_s = state_r;
        pc_nx_s    = pc_r;
        capture_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                state_nx_s = ST_FETCH;
                if (jump_en) begin
                    pc_nx_s = jump_target;
                end else begin
                    pc_nx_s = pc_r;
                end
            end
            ST_FETCH: begin
                if (jump_en) begin
                    pc_nx_s    = jump_target;
                    state_nx_s = ST_FETCH;
                end else if (mem_ack) begin
                    capture_s  = 1'b1;
                    pc_nx_s    = pc_inc;
                    state_nx_s = ST_HOLD;
                end else begin
                    state_nx_s = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (jump_en) begin
                    pc_nx_s    = jump_target;
                    state_nx_s = ST_FETCH;
                end else if (instr_ready) begin
                    state_nx_s = halt ? ST_HALT : ST_FETCH;
                end else begin
                    state_nx_s = ST_HOLD;
                end
            end
            ST_HALT: begin
                if (jump_en) begin
                    pc_nx_s    = jump_target;
                    state_nx_s = ST_FETCH;
                end else begin
                    state_nx_s = ST_HALT;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                pc_nx_s    = RESET_PC;
            end
        endcase
    end

    // State and program counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            pc_r    <= RESET_PC;
        end else begin
            state_r <= state_nx_s;
            pc_r    <= pc_nx_s;
        end
    end

    // Fetched instruction and its address, held until the next accepted ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_r    <= {INSTR_W{1'b0}};
            instr_pc_r <= {ADDR_W{1'b0}};
        end else if (capture_s) begin
            instr_r    <= mem_rdata;
            instr_pc_r <= pc_r;
        end else begin
            instr_r    <= instr_r;
            instr_pc_r <= instr_pc_r;
        end
    end

    // Handshake flags decode from state alone so reset clears them at once
    assign mem_req     = (state_r == ST_FETCH);
    assign instr_valid = (state_r == ST_HOLD);
    assign halted      = (state_r == ST_HALT);
    assign pc_out      = pc_r;
    assign mem_addr    = pc_r;
    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;

endmodule
